// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch, data and debug requesters.
// Fixed priority db > dm > if by default; define MEM_ARB_RR_EN for round-robin.
module mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,

    input  logic          db_req,
    input  logic          db_we,
    input  logic [AW-1:0] db_addr,
    input  logic [DW-1:0] db_wdata,
    output logic          db_gnt,
    output logic          db_rvalid,
    output logic [DW-1:0] db_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
    typedef enum logic [1:0] {P_IF, P_DM, P_DB} port_e;

    state_e        state_q, state_d;
    port_e         owner_q, owner_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic  any_req;
    port_e winner;

    assign any_req = if_req | dm_req | db_req;

`ifdef MEM_ARB_RR_EN
    // Search starts at the port after the last winner in the ring if -> dm -> db.
    always_comb begin
        winner = owner_q;
        case (owner_q)
            P_IF: begin
                if (dm_req)      winner = P_DM;
                else if (db_req) winner = P_DB;
                else if (if_req) winner = P_IF;
            end
            P_DM: begin
                if (db_req)      winner = P_DB;
                else if (if_req) winner = P_IF;
                else if (dm_req) winner = P_DM;
            end
            default: begin
                if (if_req)      winner = P_IF;
                else if (dm_req) winner = P_DM;
                else if (db_req) winner = P_DB;
            end
        endcase
    end
`else
    always_comb begin
        if (db_req)      winner = P_DB;
        else if (dm_req) winner = P_DM;
        else             winner = P_IF;
    end
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (any_req) begin
                    state_d  = S_ACCESS;
                    owner_d  = winner;
                    ram_en_d = 1'b1;
                    case (winner)
                        P_DM: begin
                            ram_we_d    = dm_we;
                            ram_addr_d  = dm_addr;
                            ram_wdata_d = dm_wdata;
                        end
                        P_DB: begin
                            ram_we_d    = db_we;
                            ram_addr_d  = db_addr;
                            ram_wdata_d = db_wdata;
                        end
                        default: begin
                            ram_addr_d  = if_addr;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= P_IF;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != S_IDLE);

    assign if_gnt    = (state_q == S_ACCESS) && (owner_q == P_IF);
    assign dm_gnt    = (state_q == S_ACCESS) && (owner_q == P_DM);
    assign db_gnt    = (state_q == S_ACCESS) && (owner_q == P_DB);

    assign if_rvalid = (state_q == S_RESP) && (owner_q == P_IF);
    assign dm_rvalid = (state_q == S_RESP) && (owner_q == P_DM);
    assign db_rvalid = (state_q == S_RESP) && (owner_q == P_DB);

    // Read data is steered only to the responding port; everyone else sees zero.
    assign if_rdata  = if_rvalid ? ram_rdata : '0;
    assign dm_rdata  = dm_rvalid ? ram_rdata : '0;
    assign db_rdata  = db_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a 1024x32 RAM model, three requesters and a
// transaction-level reference (arbitration policy, grant/response timing, shadow memory).
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          db_req, db_we, db_gnt, db_rvalid;
    logic [AW-1:0] db_addr;
    logic [DW-1:0] db_wdata, db_rdata;
    logic          ram_en, ram_we, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
        .db_gnt(db_gnt), .db_rvalid(db_rvalid), .db_rdata(db_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // Synchronous RAM: read data appears the cycle after ram_en.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Requester state, indexed 0 = fetch, 1 = data, 2 = debug.
    logic          req_v   [3];
    logic          we_v    [3];
    logic [AW-1:0] addr_v  [3];
    logic [DW-1:0] wdata_v [3];

    logic [DW-1:0] shadow [1024];
    int            checks = 0;
    int            errors = 0;

    logic [2:0]    prev_req;
    bit            prev_gnt_any;
    int            prev_port;
    bit            prev_we;
    logic [DW-1:0] exp_rd;
    int            last_win;
    int            grant_log [$];
    int            rvalid_count;

    function automatic int pick(input logic [2:0] r, input int last);
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
`else
        if (r[2]) return 2;
        if (r[1]) return 1;
        if (r[0]) return 0;
        return -1;
`endif
    endfunction

    task automatic drive();
        if_req  = req_v[0]; if_addr = addr_v[0];
        dm_req  = req_v[1]; dm_we = we_v[1]; dm_addr = addr_v[1]; dm_wdata = wdata_v[1];
        db_req  = req_v[2]; db_we = we_v[2]; db_addr = addr_v[2]; db_wdata = wdata_v[2];
        prev_req = {req_v[2], req_v[1], req_v[0]};
    endtask

    task automatic rand_fields(input int p);
        addr_v[p]  = AW'($urandom_range(0, 15));
        we_v[p]    = (p != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        wdata_v[p] = $urandom;
    endtask

    task automatic model_reset();
        prev_gnt_any = 0;
        prev_port    = 0;
        prev_we      = 0;
        last_win     = 0;
    endtask

    // One clock of traffic: check what the DUT shows this cycle against the reference,
    // then update the requesters (granted ports drop or re-request; idle ports may start).
    task automatic step(input bit hold, input int new_pct);
        logic [2:0]    gv, rv, egv, erv;
        logic [DW-1:0] rd [3];
        logic [DW-1:0] exp_data;
        bit            exp_we;
        int            w;
        @(posedge clk);
        @(negedge clk);
        gv = {db_gnt, dm_gnt, if_gnt};
        rv = {db_rvalid, dm_rvalid, if_rvalid};
        rd[0] = if_rdata; rd[1] = dm_rdata; rd[2] = db_rdata;

        erv = '0;
        if (prev_gnt_any) erv[prev_port] = 1'b1;
        checks++;
        if (rv !== erv) begin
            errors++;
            $display("FAIL rvalid t=%0t got %b exp %b", $time, rv, erv);
        end
        for (int p = 0; p < 3; p++) begin
            if (!(erv[p] && prev_we)) begin
                exp_data = erv[p] ? exp_rd : '0;
                checks++;
                if (rd[p] !== exp_data) begin
                    errors++;
                    $display("FAIL rdata[%0d] t=%0t got %h exp %h", p, $time, rd[p], exp_data);
                end
            end
        end

        w = prev_gnt_any ? -1 : pick(prev_req, last_win);
        egv = '0;
        if (w >= 0) egv[w] = 1'b1;
        checks++;
        if (gv !== egv) begin
            errors++;
            $display("FAIL gnt t=%0t got %b exp %b", $time, gv, egv);
        end
        checks++;
        if (busy !== ((egv != 3'b0) || (erv != 3'b0))) begin
            errors++;
            $display("FAIL busy t=%0t got %b exp %b", $time, busy, (egv != 3'b0) || (erv != 3'b0));
        end
        checks++;
        if (ram_en !== (egv != 3'b0)) begin
            errors++;
            $display("FAIL ram_en t=%0t got %b exp %b", $time, ram_en, egv != 3'b0);
        end

        if (w >= 0) begin
            exp_we = (w != 0) && we_v[w];
            checks++;
            if (ram_we !== exp_we || ram_addr !== addr_v[w]) begin
                errors++;
                $display("FAIL ram_ctl t=%0t got we=%b addr=%h exp we=%b addr=%h",
                         $time, ram_we, ram_addr, exp_we, addr_v[w]);
            end
            if (exp_we) begin
                checks++;
                if (ram_wdata !== wdata_v[w]) begin
                    errors++;
                    $display("FAIL ram_wdata t=%0t got %h exp %h", $time, ram_wdata, wdata_v[w]);
                end
                shadow[addr_v[w]] = wdata_v[w];
            end
            exp_rd   = shadow[addr_v[w]];
            prev_we  = exp_we;
            last_win = w;
            grant_log.push_back(w);
        end else begin
            checks++;
            if (ram_we !== 1'b0) begin
                errors++;
                $display("FAIL ram_we_idle t=%0t got %b exp 0", $time, ram_we);
            end
        end
        if (erv != 3'b0) rvalid_count++;
        prev_gnt_any = (w >= 0);
        if (w >= 0) prev_port = w;

        for (int p = 0; p < 3; p++) begin
            if (w == p) begin
                if (hold) rand_fields(p);
                else      req_v[p] = 1'b0;
            end else if (!req_v[p] && new_pct > 0) begin
                rand_fields(p);
                if ($urandom_range(0, 99) < new_pct) req_v[p] = 1'b1;
            end
        end
        drive();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 3; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({if_gnt, dm_gnt, db_gnt, if_rvalid, dm_rvalid, db_rvalid, ram_en, ram_we, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0",
                     {if_gnt, dm_gnt, db_gnt, if_rvalid, dm_rvalid, db_rvalid, ram_en, ram_we, busy});
        end
        checks++;
        if (ram_addr !== '0 || ram_wdata !== '0) begin
            errors++;
            $display("FAIL reset_ram got addr=%h wdata=%h exp 0", ram_addr, ram_wdata);
        end
        checks++;
        if ({if_rdata, dm_rdata, db_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h %h exp 0", if_rdata, dm_rdata, db_rdata);
        end
    endtask

    task automatic test_single_read();
        mem[5] <= 32'h0BADF00D;
        shadow[5] = 32'h0BADF00D;
        req_v[0] = 1'b1; addr_v[0] = 10'd5;
        drive();
        step(0, 0);
        checks++;
        if (if_gnt !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt got gnt=%b busy=%b exp 1 1", if_gnt, busy);
        end
        step(0, 0);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BADF00D || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_resp got rvalid=%b rdata=%h busy=%b exp 1 0badf00d 1",
                     if_rvalid, if_rdata, busy);
        end
        step(0, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_write_read();
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 10'h3FF; wdata_v[1] = 32'hDEADBEEF;
        drive();
        step(0, 0);
        step(0, 0);
        checks++;
        if (dm_rvalid !== 1'b1 || mem[10'h3FF] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_ack got rvalid=%b mem=%h exp 1 deadbeef", dm_rvalid, mem[10'h3FF]);
        end
        req_v[1] = 1'b1; we_v[1] = 1'b0; wdata_v[1] = '0;
        drive();
        step(0, 0);
        step(0, 0);
        checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_readback got rvalid=%b rdata=%h exp 1 deadbeef", dm_rvalid, dm_rdata);
        end
        step(0, 0);
    endtask

    task automatic test_contention();
        int exp_order [3];
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 2, 0};
`else
        exp_order = '{2, 1, 0};
`endif
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            req_v[p] = 1'b1; we_v[p] = 1'b0; addr_v[p] = AW'(p + 1);
        end
        drive();
        grant_log.delete();
        rvalid_count = 0;
        repeat (6) step(0, 0);
        checks++;
        if (grant_log.size() != 3 || rvalid_count != 3) begin
            errors++;
            $display("FAIL contention_count got grants=%0d resps=%0d exp 3 3", grant_log.size(), rvalid_count);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grant_log[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL contention_order[%0d] got %0d exp %0d", i, grant_log[i], exp_order[i]);
                end
            end
        end
        step(0, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_continuous();
        int exp_seq [6];
`ifdef MEM_ARB_RR_EN
        exp_seq = '{1, 2, 0, 1, 2, 0};
`else
        exp_seq = '{2, 2, 2, 2, 2, 2};
`endif
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            rand_fields(p);
            req_v[p] = 1'b1;
        end
        drive();
        grant_log.delete();
        repeat (12) step(1, 0);
        checks++;
        if (grant_log.size() != 6) begin
            errors++;
            $display("FAIL continuous_count got %0d exp 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grant_log[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL continuous_seq[%0d] got %0d exp %0d", i, grant_log[i], exp_seq[i]);
                end
            end
        end
        for (int p = 0; p < 3; p++) req_v[p] = 1'b0;
        drive();
        repeat (3) step(0, 0);
    endtask

    task automatic test_fetch_drop();
        int fetch_grants;
        apply_reset();
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 10'd7;
        drive();
        step(0, 0);
        req_v[0] = 1'b1; addr_v[0] = 10'd9;
        drive();
        grant_log.delete();
        step(0, 0);
        req_v[0] = 1'b0;
        drive();
        repeat (3) step(0, 0);
        fetch_grants = 0;
        foreach (grant_log[i]) if (grant_log[i] == 0) fetch_grants++;
        checks++;
        if (fetch_grants != 0) begin
            errors++;
            $display("FAIL fetch_drop got %0d fetch grants exp 0", fetch_grants);
        end
        // Data port idles with write-enable high while fetch is served.
        we_v[1] = 1'b1; wdata_v[1] = 32'hFFFF_FFFF;
        req_v[0] = 1'b1; addr_v[0] = 10'd9;
        drive();
        step(0, 0);
        checks++;
        if (if_gnt !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_we got gnt=%b ram_we=%b exp 1 0", if_gnt, ram_we);
        end
        repeat (2) step(0, 0);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] old;
        apply_reset();
        old = shadow[20];
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 10'd20; wdata_v[1] = ~old;
        drive();
        step(0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if_gnt, dm_gnt, db_gnt, if_rvalid, dm_rvalid, db_rvalid, ram_en, ram_we, busy} !== 9'b0) begin
            errors++;
            $display("FAIL midreset_ctl got %b exp 0",
                     {if_gnt, dm_gnt, db_gnt, if_rvalid, dm_rvalid, db_rvalid, ram_en, ram_we, busy});
        end
        for (int p = 0; p < 3; p++) req_v[p] = 1'b0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        shadow[20] = old;
        rvalid_count = 0;
        repeat (4) step(0, 0);
        checks++;
        if (rvalid_count != 0 || mem[20] !== old) begin
            errors++;
            $display("FAIL midreset_after got resps=%0d mem=%h exp 0 %h", rvalid_count, mem[20], old);
        end
    endtask

    task automatic test_random();
        apply_reset();
        rvalid_count = 0;
        grant_log.delete();
        repeat (3000) step(1'($urandom_range(0, 1)), 40);
        repeat (10) step(0, 0);
        checks++;
        if (rvalid_count != grant_log.size() || rvalid_count < 100) begin
            errors++;
            $display("FAIL random_total got resps=%0d grants=%0d exp equal and >=100",
                     rvalid_count, grant_log.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem[i] <= v;
            shadow[i] = v;
        end
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_continuous();
        test_fetch_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
